// File: rtl/p23_divider_iter.sv
// p23_divider_iter: iterative restoring divider (radix 2^BITS_PER_CYCLE) with RISC-V special cases.
// Optional quotient/remainder reuse cache enabled by DIV_RESULT_CACHE_EN.
module p23_divider_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [1:0]      divop,
    input  logic            div_valid,
    output logic            div_ready,
    output logic [XLEN-1:0] div_result,
    output logic            div_by_zero_err,
    output logic            busy
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, CALC, FIXUP, DONE, HOLD} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo, dsr, q_step, q_fin, r_fin, a_mag, b_mag, sp_q, sp_r;
    logic [XLEN:0]   rem, r_step;
    logic            q_neg, r_neg, is_rem, ge;
    logic            is_signed_in, zero_in, ovf_in, special_in, hit, accept;
    logic [XLEN-1:0] c_q_sel, c_r_sel;

    always_comb begin
        is_signed_in = ~divop[0];
        zero_in      = divisor == '0;
        ovf_in       = is_signed_in && dividend == {1'b1, {(XLEN-1){1'b0}}} && &divisor;
        special_in   = zero_in | ovf_in;
        accept       = state == IDLE && div_valid;
        a_mag        = (is_signed_in && dividend[XLEN-1]) ? -dividend : dividend;
        b_mag        = (is_signed_in && divisor[XLEN-1]) ? -divisor : divisor;
        sp_q         = zero_in ? '1 : dividend;
        sp_r         = zero_in ? dividend : '0;
        q_fin        = q_neg ? -quo : quo;
        r_fin        = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    end

    // Partial remainder is XLEN+1 bits wide so a MIN magnitude divides exactly.
    always_comb begin
        r_step = rem;
        q_step = quo;
        ge     = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r_step = {r_step[XLEN-1:0], q_step[XLEN-1]};
            ge     = r_step >= {1'b0, dsr};
            r_step = ge ? r_step - {1'b0, dsr} : r_step;
            q_step = {q_step[XLEN-2:0], ge};
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    logic            c_valid, c_signed, s_reg;
    logic [XLEN-1:0] c_dividend, c_divisor, c_q, c_r, a_reg, b_reg;

    always_comb begin
        hit     = c_valid && c_dividend == dividend && c_divisor == divisor && c_signed == is_signed_in;
        c_q_sel = c_q;
        c_r_sel = c_r;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= dividend;
            b_reg <= divisor;
            s_reg <= is_signed_in;
        end
        if (reset) begin
            c_valid <= 1'b0;
        end else if (accept && special_in) begin
            c_valid    <= 1'b1;
            c_dividend <= dividend;
            c_divisor  <= divisor;
            c_signed   <= is_signed_in;
            c_q        <= sp_q;
            c_r        <= sp_r;
        end else if (state == FIXUP) begin
            c_valid    <= 1'b1;
            c_dividend <= a_reg;
            c_divisor  <= b_reg;
            c_signed   <= s_reg;
            c_q        <= q_fin;
            c_r        <= r_fin;
        end
    end
`else
    always_comb begin
        hit     = 1'b0;
        c_q_sel = '0;
        c_r_sel = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = div_valid ? ((special_in || hit) ? DONE : CALC) : IDLE;
            CALC:    state_nxt = cnt == CW'(1) ? FIXUP : CALC;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = HOLD;
            HOLD:    state_nxt = div_valid ? HOLD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        div_ready = state == DONE;
        busy      = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cnt    <= CW'(N);
            quo    <= a_mag;
            dsr    <= b_mag;
            rem    <= '0;
            q_neg  <= is_signed_in & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_neg  <= is_signed_in & dividend[XLEN-1];
            is_rem <= divop[1];
        end else if (state == CALC) begin
            cnt <= cnt - 1'b1;
            quo <= q_step;
            rem <= r_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_result      <= '0;
            div_by_zero_err <= 1'b0;
        end else if (accept) begin
            div_by_zero_err <= zero_in;
            if (special_in)
                div_result <= divop[1] ? sp_r : sp_q;
            else if (hit)
                div_result <= divop[1] ? c_r_sel : c_q_sel;
        end else if (state == FIXUP) begin
            div_result <= is_rem ? r_fin : q_fin;
        end
    end
endmodule

// File: tb/tb_p23_divider_iter.sv
// tb_p23_divider_iter: scoreboard bench for p23_divider_iter at BITS_PER_CYCLE 1 and 4.
// Build with DIV_RESULT_CACHE_EN to also exercise the reuse cache.
module tb_p23_divider_iter;
    logic        clk = 0;
    logic        reset = 1;
    logic [31:0] dividend = 0, divisor = 0;
    logic [1:0]  divop = 0;
    logic [1:0]  valid = 0, ready, err, busy;
    logic [31:0] res [2];
    int          checks = 0, errors = 0;

    typedef struct {
        logic [31:0] r;
        logic        e;
        int          lat;
    } exp_t;
    exp_t sb[$];

`ifdef DIV_RESULT_CACHE_EN
    logic        mc_v [2];
    logic        mc_s [2];
    logic [31:0] mc_a [2], mc_b [2];
`endif

    always #5 clk = ~clk;

    p23_divider_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor), .divop(divop),
        .div_valid(valid[0]), .div_ready(ready[0]), .div_result(res[0]),
        .div_by_zero_err(err[0]), .busy(busy[0])
    );

    p23_divider_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor), .divop(divop),
        .div_valid(valid[1]), .div_ready(ready[1]), .div_result(res[1]),
        .div_by_zero_err(err[1]), .busy(busy[1])
    );

    function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, b);
        return b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, b);
        if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : a;
        if (!op[0]) return op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int exp_lat(input int w, input logic [1:0] op, input logic [31:0] a, b);
        if (is_special(op, a, b)) return 1;
`ifdef DIV_RESULT_CACHE_EN
        if (mc_v[w] && mc_a[w] == a && mc_b[w] == b && mc_s[w] == !op[0]) return 1;
`endif
        return w == 0 ? 34 : 10;
    endfunction

    task automatic clear_model_cache();
`ifdef DIV_RESULT_CACHE_EN
        for (int i = 0; i < 2; i++) mc_v[i] = 0;
`endif
    endtask

    task automatic do_op(input int w, input logic [1:0] op, input logic [31:0] a, b, exp_r,
                         input int lat, input int hold);
        exp_t e;
        int   cnt;
        e.r = exp_r; e.e = (b == 0); e.lat = lat;
        sb.push_back(e);
        dividend = a; divisor = b; divop = op; valid[w] = 1;
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
        end while (!ready[w] && cnt < 200);
        e = sb.pop_front();
        checks++;
        if (ready[w] !== 1'b1) begin
            errors++; $display("FAIL ready_timeout dut%0d op=%0d %h/%h: no div_ready in %0d cycles", w, op, a, b, cnt);
        end
        checks++;
        if (res[w] !== e.r) begin
            errors++; $display("FAIL result dut%0d op=%0d %h/%h: got %h expected %h", w, op, a, b, res[w], e.r);
        end
        checks++;
        if (err[w] !== e.e) begin
            errors++; $display("FAIL dz_err dut%0d op=%0d %h/%h: got %b expected %b", w, op, a, b, err[w], e.e);
        end
        checks++;
        if (cnt !== e.lat) begin
            errors++; $display("FAIL latency dut%0d op=%0d %h/%h: got %0d expected %0d", w, op, a, b, cnt, e.lat);
        end
`ifdef DIV_RESULT_CACHE_EN
        mc_v[w] = 1; mc_a[w] = a; mc_b[w] = b; mc_s[w] = !op[0];
`endif
        dividend = $urandom; divisor = $urandom;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready[w] !== 1'b0 || busy[w] !== 1'b1) begin
                errors++; $display("FAIL hold_retrigger dut%0d cycle %0d: ready=%b busy=%b expected ready=0 busy=1", w, i, ready[w], busy[w]);
            end
        end
        valid[w] = 0;
        if (hold == 0) begin
            @(posedge clk); #1;
            checks++;
            if (ready[w] !== 1'b0) begin
                errors++; $display("FAIL ready_pulse dut%0d: ready=%b expected 0", w, ready[w]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (busy[w] !== 1'b0) begin
            errors++; $display("FAIL back_to_idle dut%0d: busy=%b expected 0", w, busy[w]);
        end
    endtask

    task automatic test_reset();
        reset = 1; valid = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        clear_model_cache();
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (ready[w] !== 0 || res[w] !== 0 || err[w] !== 0 || busy[w] !== 0) begin
                errors++; $display("FAIL reset_state dut%0d: ready=%b result=%h err=%b busy=%b expected all 0", w, ready[w], res[w], err[w], busy[w]);
            end
        end
    endtask

    task automatic test_special();
        do_op(0, 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
        do_op(0, 2'b10, 32'd5, 32'd0, 32'd5, 1, 0);
        do_op(0, 2'b01, 32'd9, 32'd3, 32'd3, exp_lat(0, 2'b01, 32'd9, 32'd3), 0);
        do_op(0, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        do_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0);
        do_op(1, 2'b00, 32'hFFFFFFEC, 32'd0, 32'hFFFFFFFF, 1, 0);
    endtask

    task automatic test_basic();
        do_op(0, 2'b01, 32'd100, 32'd7, 32'd14, exp_lat(0, 2'b01, 32'd100, 32'd7), 0);
        do_op(0, 2'b11, 32'd100, 32'd7, 32'd2, exp_lat(0, 2'b11, 32'd100, 32'd7), 0);
        do_op(0, 2'b00, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, exp_lat(0, 2'b00, 32'hFFFFFFEC, 32'd3), 0);
        do_op(0, 2'b10, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, exp_lat(0, 2'b10, 32'hFFFFFFEC, 32'd3), 0);
        do_op(0, 2'b00, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, exp_lat(0, 2'b00, 32'd20, 32'hFFFFFFFD), 0);
    endtask

    task automatic test_abort();
        int pulses = 0;
        dividend = 32'd777; divisor = 32'd5; divop = 2'b01; valid[0] = 1;
        repeat (10) @(posedge clk);
        #1 reset = 1; valid[0] = 0;
        @(posedge clk);
        #1 reset = 0;
        clear_model_cache();
        checks++;
        if (busy[0] !== 0 || res[0] !== 0 || ready[0] !== 0 || err[0] !== 0) begin
            errors++; $display("FAIL abort_state: busy=%b result=%h ready=%b err=%b expected all 0", busy[0], res[0], ready[0], err[0]);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (ready[0]) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses);
        end
        do_op(0, 2'b01, 32'd1000, 32'd33, 32'd30, 34, 0);
    endtask

    task automatic test_back_to_back_bpc4();
        do_op(1, 2'b01, 32'd1000, 32'd33, 32'd30, 10, 5);
        do_op(1, 2'b00, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, exp_lat(1, 2'b00, 32'hFFFFFFEC, 32'd3), 0);
        do_op(1, 2'b10, 32'h80000000, 32'd7, 32'hFFFFFFFE, exp_lat(1, 2'b10, 32'h80000000, 32'd7), 0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [1:0]  op;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 300));
                3: b = -32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            do_op(i % 2, op, a, b, model(op, a, b), exp_lat(i % 2, op, a, b), 0);
        end
    endtask

`ifdef DIV_RESULT_CACHE_EN
    task automatic test_cache();
        do_op(0, 2'b00, 32'd1000, 32'd33, 32'd30, 34, 0);
        do_op(0, 2'b10, 32'd1000, 32'd33, 32'd10, 1, 0);
        do_op(0, 2'b11, 32'd1000, 32'd33, 32'd10, 34, 0);
        do_op(0, 2'b10, 32'd1234, 32'd0, 32'd1234, 1, 0);
        do_op(0, 2'b00, 32'd1234, 32'd0, 32'hFFFFFFFF, 1, 0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_special();
        test_basic();
        test_abort();
        test_back_to_back_bpc4();
        test_random();
`ifdef DIV_RESULT_CACHE_EN
        test_cache();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
